// File: rtl/gpu_def.sv
// Shared definitions for the GPU copy state machines: VRAM->CPU copy states,
// the memory command size code and the burst address helper.
package gpu_def;

  typedef enum logic [2:0] {
    VC_WAIT,
    VC_START,
    VC_REQ,
    VC_DATA,
    VC_DRAIN,
    VC_FLUSH
  } vcState_t;

  localparam logic [1:0] CMD_SIZE_32B = 2'd1;

  // Burst address of the 16-pixel block that holds pixel (base + offset).
  // X wraps at 1024 and Y wraps at 512.
  function automatic logic [14:0] vcAdr(input logic [9:0] baseX, input logic [8:0] baseY,
                                        input logic [9:0] offX, input logic [8:0] offY);
    return {9'(baseY + offY), 6'((baseX + offX) >> 4)};
  endfunction

endpackage

// File: rtl/gpu_vc_pixel_packer.sv
// Packs a 16-bit pixel stream into 32-bit GPUREAD words {second, first}.
// A completed word waits in a held register until the FIFO has room.
module gpu_vc_pixel_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        pixelValid,
  input  logic [15:0] pixel,
  input  logic        flush,
  input  logic        i_fifoFull,
  output logic        ready,
  output logic        o_fifoWrite,
  output logic [31:0] o_fifoData,
  output logic        flushDone
);

  logic        halfValid;
  logic [15:0] halfPixel;
  logic        heldValid;

  // A held word blocked by a full FIFO freezes the pixel stream.
  assign ready       = !(heldValid && i_fifoFull);
  assign o_fifoWrite = heldValid && !i_fifoFull;
  assign flushDone   = flush && (!halfValid || ready);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halfValid  <= 1'b0;
      halfPixel  <= '0;
      heldValid  <= 1'b0;
      o_fifoData <= '0;
    end else begin
      // NOTE: non-blocking updates let a later assignment in this block
      // override the push-clear, so a new word can replace one leaving.
      if (o_fifoWrite) heldValid <= 1'b0;
      if (pixelValid && ready) begin
        if (halfValid) begin
          o_fifoData <= {pixel, halfPixel};
          heldValid  <= 1'b1;
          halfValid  <= 1'b0;
        end else begin
          halfPixel <= pixel;
          halfValid <= 1'b1;
        end
      end else if (flush && halfValid && ready) begin
        o_fifoData <= {16'h0000, halfPixel};
        heldValid  <= 1'b1;
        halfValid  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gpu_sm_copyvc_mem.sv
// VRAM->CPU copy engine: walks the source rectangle in 32-byte read bursts and
// feeds pixels to the GPUREAD packer. GPU_VC_PREFETCH_EN enables double buffering.
module gpu_sm_copyvc_mem
  import gpu_def::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_activateCopyVC,
  output logic               o_CopyInactiveNextCycle,
  output logic               o_active,
  input  logic signed [11:0] RegX0,
  input  logic signed [11:0] RegY0,
  input  logic        [10:0] RegSizeW,
  input  logic        [9:0]  RegSizeH,
  output logic               o_command,
  input  logic               i_busy,
  output logic        [1:0]  o_commandSize,
  output logic               o_write,
  output logic        [14:0] o_adr,
  output logic        [2:0]  o_subadr,
  input  logic        [255:0] i_dataIn,
  input  logic               i_dataInValid,
  output logic               o_fifoWrite,
  output logic        [31:0] o_fifoData,
  input  logic               i_fifoFull
);

`ifdef GPU_VC_PREFETCH_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  vcState_t    state;
  logic [9:0]  baseX;
  logic [8:0]  baseY;
  logic [10:0] sizeW;
  logic [9:0]  sizeH;
  logic [10:0] x;
  logic [9:0]  y;
  logic [10:0] reqX;
  logic [9:0]  reqY;
  logic        reqLeft;
  logic [1:0]  outstanding;
  logic [1:0]  bufValid;
  logic        wrPtr;
  logic        rdPtr;
  logic [255:0] blockBuf [2];

  logic unusedRegBits;
  assign unusedRegBits = ^{RegX0[11:10], RegY0[11:9]};

  assign o_commandSize = CMD_SIZE_32B;
  assign o_write       = 1'b0;
  assign o_subadr      = 3'd0;
  assign o_active      = (state != VC_WAIT);

  // Drain side: the pixel index inside the block follows the screen X directly.
  logic [3:0]  pixIdx;
  logic        lineEnd, lastPix, blockEnd, oddTotal;
  logic [15:0] drainPixel;
  assign pixIdx     = baseX[3:0] + x[3:0];
  assign lineEnd    = (x + 11'd1 == sizeW);
  assign lastPix    = lineEnd && (y + 10'd1 == sizeH);
  assign blockEnd   = (pixIdx == 4'hF) || lineEnd;
  assign oddTotal   = sizeW[0] & sizeH[0];
  assign drainPixel = blockBuf[rdPtr][{pixIdx, 4'h0} +: 16];

  // Request side: span of the block at reqX and the position after it.
  logic [3:0]  reqLow;
  logic [4:0]  blockRoom;
  logic [10:0] lineRoom, reqCount, reqXNext, reqXAdv;
  logic [9:0]  reqYAdv;
  logic        reqLineEnd, reqLast;
  assign reqLow     = baseX[3:0] + reqX[3:0];
  assign blockRoom  = 5'd16 - {1'b0, reqLow};
  assign lineRoom   = sizeW - reqX;
  assign reqCount   = ({6'd0, blockRoom} < lineRoom) ? {6'd0, blockRoom} : lineRoom;
  assign reqXNext   = reqX + reqCount;
  assign reqLineEnd = (reqXNext == sizeW);
  assign reqXAdv    = reqLineEnd ? 11'd0 : reqXNext;
  assign reqYAdv    = reqLineEnd ? reqY + 10'd1 : reqY;
  assign reqLast    = reqLineEnd && (reqY + 10'd1 == sizeH);

  logic [2:0] inFlight;
  logic       issue, capture, accept, nextBufReady, packReady, flushDone;
  assign inFlight = {1'b0, outstanding} + {2'b0, bufValid[0]} + {2'b0, bufValid[1]};
  assign issue    = (state == VC_REQ || state == VC_DATA || state == VC_DRAIN)
                    && reqLeft && (inFlight < 3'(NBUF)) && !i_busy;
  assign o_command = issue;
  assign capture  = i_dataInValid && (outstanding != 2'd0);
  assign accept   = (state == VC_DRAIN) && packReady;
  assign nextBufReady = (NBUF == 2) &&
                        (bufValid[!rdPtr] || (capture && wrPtr == !rdPtr));

  assign o_CopyInactiveNextCycle =
      (accept && lastPix && !oddTotal) || ((state == VC_FLUSH) && flushDone);

  // NOTE: the burst buffers carry no reset; every slot is written before its
  // valid flag is set, and the flags themselves are reset.
  always_ff @(posedge i_clk) begin
    if (capture) blockBuf[wrPtr] <= i_dataIn;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= VC_WAIT;
      baseX       <= '0;
      baseY       <= '0;
      sizeW       <= '0;
      sizeH       <= '0;
      x           <= '0;
      y           <= '0;
      reqX        <= '0;
      reqY        <= '0;
      reqLeft     <= 1'b0;
      outstanding <= '0;
      bufValid    <= '0;
      wrPtr       <= 1'b0;
      rdPtr       <= 1'b0;
      o_adr       <= '0;
    end else begin
      if (issue) begin
        reqX    <= reqXAdv;
        reqY    <= reqYAdv;
        reqLeft <= !reqLast;
        o_adr   <= vcAdr(baseX, baseY, reqXAdv[9:0], reqYAdv[8:0]);
      end
      outstanding <= outstanding + {1'b0, issue} - {1'b0, capture};
      if (capture) begin
        bufValid[wrPtr] <= 1'b1;
        if (NBUF == 2) wrPtr <= !wrPtr;
      end
      if (accept) begin
        if (lineEnd) begin
          x <= '0;
          y <= y + 10'd1;
        end else begin
          x <= x + 11'd1;
        end
        if (blockEnd) begin
          bufValid[rdPtr] <= 1'b0;
          if (NBUF == 2) rdPtr <= !rdPtr;
        end
      end

      case (state)
        VC_WAIT: if (i_activateCopyVC) begin
          baseX <= RegX0[9:0];
          baseY <= RegY0[8:0];
          sizeW <= RegSizeW;
          sizeH <= RegSizeH;
          state <= VC_START;
        end
        VC_START: begin
          x        <= '0;
          y        <= '0;
          reqX     <= '0;
          reqY     <= '0;
          reqLeft  <= 1'b1;
          bufValid <= '0;
          wrPtr    <= 1'b0;
          rdPtr    <= 1'b0;
          o_adr    <= vcAdr(baseX, baseY, 10'd0, 9'd0);
          state    <= VC_REQ;
        end
        VC_REQ: if (issue) state <= VC_DATA;
        VC_DATA: if (bufValid[rdPtr] || (capture && wrPtr == rdPtr)) state <= VC_DRAIN;
        VC_DRAIN: if (accept && blockEnd) begin
          if (lastPix)                              state <= oddTotal ? VC_FLUSH : VC_WAIT;
          else if (nextBufReady)                    state <= VC_DRAIN;
          else if (outstanding != 2'd0 || issue)    state <= VC_DATA;
          else                                      state <= VC_REQ;
        end
        VC_FLUSH: if (flushDone) state <= VC_WAIT;
        default: state <= VC_WAIT;
      endcase
    end
  end

  gpu_vc_pixel_packer packer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .pixelValid (state == VC_DRAIN),
    .pixel      (drainPixel),
    .flush      (state == VC_FLUSH),
    .i_fifoFull (i_fifoFull),
    .ready      (packReady),
    .o_fifoWrite(o_fifoWrite),
    .o_fifoData (o_fifoData),
    .flushDone  (flushDone)
  );

endmodule
